seg7_display_decoder: RTL and testbench

//  Receive side of the seven-segment display interface: samples NUM_DIGITS active-low 7-seg buses,

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7_digit_decode.sv | 23 ++
 rtl/seg7_display_decoder.sv | 133 +++++++++++++
 tb/tb_seg7_display_decoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment readback decoder: glyph table and FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  // Active-low glyphs, a = bit0; element n is the pattern for hex digit n.
  localparam logic [15:0][6:0] SEG7_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} seg7_dec_state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one active-low 7-segment pattern back to its hex nibble.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       bad
);

  always_comb begin
    nibble = 4'd0;
    blank  = (seg == SEG7_BLANK);
    bad    = !blank;
    for (int i = 0; i < 16; i++) begin
      if (!blank && seg == SEG7_GLYPH[i]) begin
        nibble = 4'(i);
        bad    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_display_decoder.sv
// Readback monitor: waits for the 7-seg buses to settle after a done rise, then decodes them.
module seg7_display_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    done,
  input  logic [NUM_DIGITS*7-1:0] seg_in,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    value_valid,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   bad_mask,
  output logic                    timeout_err,
  output logic                    busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  seg7_dec_state_t           state_reg, state_next;
  logic                      done_q_reg;
  logic [NUM_DIGITS*7-1:0]   seg_q_reg, seg_q_next;
  logic [CW-1:0]             stab_cnt_reg, stab_cnt_next;
  logic [CW-1:0]             tmo_cnt_reg, tmo_cnt_next;
  logic [4*NUM_DIGITS-1:0]   value_reg, value_next;
  logic [NUM_DIGITS-1:0]     blank_reg, blank_next;
  logic [NUM_DIGITS-1:0]     bad_reg, bad_next;
  logic                      valid_reg, valid_next;
  logic                      tmo_err_reg, tmo_err_next;

  logic [4*NUM_DIGITS-1:0]   dec_value;
  logic [NUM_DIGITS-1:0]     dec_blank;
  logic [NUM_DIGITS-1:0]     dec_bad;
  logic                      rise;
  logic                      same;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    seg7_digit_decode u_dec (
      .seg    (seg_q_reg[7*gi +: 7]),
      .nibble (dec_value[4*gi +: 4]),
      .blank  (dec_blank[gi]),
      .bad    (dec_bad[gi])
    );
  end

  assign rise = done & ~done_q_reg;
  assign same = (seg_in == seg_q_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      done_q_reg   <= 1'b0;
      seg_q_reg    <= '0;
      stab_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      value_reg    <= '0;
      blank_reg    <= '0;
      bad_reg      <= '0;
      valid_reg    <= 1'b0;
      tmo_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      done_q_reg   <= done;
      seg_q_reg    <= seg_q_next;
      stab_cnt_reg <= stab_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      value_reg    <= value_next;
      blank_reg    <= blank_next;
      bad_reg      <= bad_next;
      valid_reg    <= valid_next;
      tmo_err_reg  <= tmo_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    seg_q_next    = seg_q_reg;
    stab_cnt_next = stab_cnt_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    value_next    = value_reg;
    blank_next    = blank_reg;
    bad_next      = bad_reg;
    valid_next    = 1'b0;
    tmo_err_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next    = SETTLE;
          seg_q_next    = seg_in;
          stab_cnt_next = '0;
          tmo_cnt_next  = '0;
        end
      end
      SETTLE: begin
        seg_q_next    = seg_in;
        tmo_cnt_next  = (tmo_cnt_reg == CNT_MAX) ? tmo_cnt_reg : tmo_cnt_reg + 1'b1;
        stab_cnt_next = !same ? '0 :
                        (stab_cnt_reg == CNT_MAX) ? stab_cnt_reg : stab_cnt_reg + 1'b1;
        // A dropped done abandons the capture silently, even if settling just completed.
        if (!done) begin
          state_next = IDLE;
        end else if (same && stab_cnt_reg == STAB_LAST) begin
          state_next = CAPTURE;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next   = IDLE;
          tmo_err_next = 1'b1;
        end
      end
      CAPTURE: begin
        value_next = dec_value;
        blank_next = dec_blank;
        bad_next   = dec_bad;
        valid_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign value       = value_reg;
  assign value_valid = valid_reg;
  assign blank_mask  = blank_reg;
  assign bad_mask    = bad_reg;
  assign timeout_err = tmo_err_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_seg7_display_decoder.sv
// Directed bench for seg7_display_decoder (6 digits, STABLE_CYCLES=2, TIMEOUT_CYCLES=16).
module tb_seg7_display_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        done;
  logic [41:0] seg_in;
  logic [23:0] value;
  logic        value_valid;
  logic [5:0]  blank_mask;
  logic [5:0]  bad_mask;
  logic        timeout_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  seg7_display_decoder #(
    .NUM_DIGITS     (6),
    .STABLE_CYCLES  (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .done        (done),
    .seg_in      (seg_in),
    .value       (value),
    .value_valid (value_valid),
    .blank_mask  (blank_mask),
    .bad_mask    (bad_mask),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] pack6(input logic [6:0] h5, input logic [6:0] h4,
                                        input logic [6:0] h3, input logic [6:0] h2,
                                        input logic [6:0] h1, input logic [6:0] h0);
    return {h5, h4, h3, h2, h1, h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop done for a cycle and raise it; returns just before the edge that sees the rise.
  task automatic arm();
    done = 1'b0;
    tick();
    done = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    done   = 1'b0;
    seg_in = '1;
    tick();
    tick();
    vectors++;
    if ({value, value_valid, blank_mask, bad_mask, timeout_err, busy} !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got value=%h vv=%b blank=%b bad=%b to=%b busy=%b, want all 0",
               value, value_valid, blank_mask, bad_mask, timeout_err, busy);
    end
    rst_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_basic();
    seg_in = pack6(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
    arm();
    tick();  // edge k
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      vectors++;
      if (value_valid !== (e == 3)) begin
        miscompares++;
        $display("FAIL basic_latency: edge k+%0d value_valid=%b want %b", e, value_valid, (e == 3));
      end
    end
    vectors++;
    if (value !== 24'h012345 || blank_mask !== 6'd0 || bad_mask !== 6'd0) begin
      miscompares++;
      $display("FAIL basic_value: got %h/%b/%b want 012345/000000/000000", value, blank_mask, bad_mask);
    end
    tick();
    vectors++;
    if (value_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_pulse_end: vv=%b busy=%b want 0 0", value_valid, busy);
    end
    $display("basic capture value=%h", value);
  endtask

  task automatic test_settle_restart();
    seg_in = pack6(7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F);
    arm();
    tick();  // edge k: seg_q holds the pre-change pattern
    seg_in = pack6(7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E);
    for (int e = 1; e <= 4; e++) begin
      tick();
      vectors++;
      if (value_valid !== (e == 4)) begin
        miscompares++;
        $display("FAIL restart_latency: edge k+%0d value_valid=%b want %b", e, value_valid, (e == 4));
      end
    end
    vectors++;
    if (value !== 24'hABCDEF) begin
      miscompares++;
      $display("FAIL restart_value: got %h want abcdef", value);
    end
    $display("restart capture value=%h", value);
    done = 1'b0;
  endtask

  task automatic test_masks();
    seg_in = pack6(7'h7F, 7'h7F, 7'h00, 7'h00, 7'h00, 7'h00);
    arm();
    for (int e = 0; e < 4; e++) tick();
    vectors++;
    if (value_valid !== 1'b1 || value !== 24'h008888 || blank_mask !== 6'b110000 || bad_mask !== 6'd0) begin
      miscompares++;
      $display("FAIL blank_capture: vv=%b value=%h blank=%b bad=%b want 1 008888 110000 000000",
               value_valid, value, blank_mask, bad_mask);
    end
    $display("blank capture value=%h blank=%b", value, blank_mask);
    seg_in = pack6(7'h7F, 7'h7F, 7'h00, 7'h00, 7'h55, 7'h00);
    arm();
    for (int e = 0; e < 4; e++) tick();
    vectors++;
    if (value_valid !== 1'b1 || value !== 24'h008808 || blank_mask !== 6'b110000 || bad_mask !== 6'b000010) begin
      miscompares++;
      $display("FAIL bad_capture: vv=%b value=%h blank=%b bad=%b want 1 008808 110000 000010",
               value_valid, value, blank_mask, bad_mask);
    end
    $display("bad capture value=%h bad=%b", value, bad_mask);
  endtask

  task automatic test_timeout();
    int vv_seen = 0;
    seg_in = pack6(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    arm();
    tick();  // edge k
    for (int e = 1; e <= 16; e++) begin
      seg_in[6:0] = (seg_in[6:0] == 7'h00) ? 7'h79 : 7'h00;
      tick();
      if (value_valid) vv_seen++;
      vectors++;
      if (timeout_err !== (e == 16)) begin
        miscompares++;
        $display("FAIL timeout_pulse: edge k+%0d timeout_err=%b want %b", e, timeout_err, (e == 16));
      end
    end
    tick();
    if (value_valid) vv_seen++;
    vectors++;
    if (timeout_err !== 1'b0 || busy !== 1'b0 || vv_seen != 0 || value !== 24'h008808) begin
      miscompares++;
      $display("FAIL timeout_after: to=%b busy=%b valids=%0d value=%h want 0 0 0 008808",
               timeout_err, busy, vv_seen, value);
    end
    $display("timeout observed, value=%h", value);
    done = 1'b0;
  endtask

  task automatic test_abort();
    int pulses = 0;
    seg_in = pack6(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79);
    arm();
    tick();  // edge k, in SETTLE
    done = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      if (value_valid || timeout_err) pulses++;
    end
    vectors++;
    if (pulses != 0 || busy !== 1'b0 || value !== 24'h008808) begin
      miscompares++;
      $display("FAIL done_drop: pulses=%0d busy=%b value=%h want 0 0 008808", pulses, busy, value);
    end
    arm();
    for (int e = 0; e < 4; e++) tick();
    vectors++;
    if (value_valid !== 1'b1 || value !== 24'h000001 || bad_mask !== 6'd0 || blank_mask !== 6'd0) begin
      miscompares++;
      $display("FAIL after_drop: vv=%b value=%h want 1 000001", value_valid, value);
    end
    $display("post-drop capture value=%h", value);

    seg_in = pack6(7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24);
    arm();
    tick();  // edge k, in SETTLE
    rst_n = 1'b0;
    done  = 1'b0;
    #1;
    vectors++;
    if ({value, value_valid, blank_mask, bad_mask, timeout_err, busy} !== 40'd0) begin
      miscompares++;
      $display("FAIL mid_reset: value=%h vv=%b busy=%b want all 0", value, value_valid, busy);
    end
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int e = 0; e < 3; e++) begin
      tick();
      if (value_valid || timeout_err) pulses++;
    end
    arm();
    for (int e = 0; e < 4; e++) tick();
    vectors++;
    if (pulses != 0 || value_valid !== 1'b1 || value !== 24'h222222) begin
      miscompares++;
      $display("FAIL after_reset: pulses=%0d vv=%b value=%h want 0 1 222222", pulses, value_valid, value);
    end
    $display("post-reset capture value=%h", value);
  endtask

  task automatic test_back_to_back();
    int count = 0;
    seg_in = pack6(7'h10, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30);
    arm();
    for (int e = 0; e < 16; e++) begin
      tick();
      if (value_valid) count++;
    end
    vectors++;
    if (count != 1 || value !== 24'h976543) begin
      miscompares++;
      $display("FAIL held_done: valids=%0d value=%h want 1 976543", count, value);
    end
    $display("held-done capture value=%h pulses=%0d", value, count);
    seg_in = pack6(7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h40);
    arm();
    count = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (value_valid) count++;
    end
    vectors++;
    if (count != 1 || value !== 24'hFFFFF0) begin
      miscompares++;
      $display("FAIL rerise: valids=%0d value=%h want 1 fffff0", count, value);
    end
    $display("re-rise capture value=%h pulses=%0d", value, count);
    done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_settle_restart();
    test_masks();
    test_timeout();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
